// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with a valid/ready holding register
// Reports framing errors and overruns as single-cycle pulses; never stalls the line.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rx_s;
  logic            cnt_half;
  logic            cnt_full;
  logic            stop_sample;

  assign rx_s        = sync2_q;
  assign cnt_half    = (cnt_q == HALF_M1);
  assign cnt_full    = (cnt_q == BIT_M1);
  assign stop_sample = (state_q == S_STOP) && cnt_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!rx_s) state_d = S_START;
      S_START:   if (cnt_half) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:    if (cnt_full && (idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:    if (cnt_full) state_d = rx_s ? S_IDLE : S_RECOVER;
      S_RECOVER: if (rx_s) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = '0;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: idx_d = '0;
      S_START: cnt_d = cnt_half ? '0 : cnt_q + CW'(1);
      S_DATA: begin
        if (cnt_full) begin
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: if (!cnt_full) cnt_d = cnt_q + CW'(1);
      default: cnt_d = '0;
    endcase

    // A delivery and a consumer accept in the same cycle resolve together.
    if (stop_sample && rx_s) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    if (stop_sample && !rx_s) frame_err_d = 1'b1;
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed bench for uart_receiver
// The model predicts events from E0-relative sample offsets over the recorded line history.
module tb_uart_receiver;

  localparam int C4 = 4;
  localparam int H4 = C4 / 2;

  logic       clk = 1'b0;
  logic       rst4, rst234;
  logic       rx4, rx234;
  logic       ready4, ready234;
  logic [7:0] data4, data234;
  logic       valid4, valid234;
  logic       fe4, fe234;
  logic       ov4, ov234;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = -1;
  bit armed   = 1'b0;
  bit rand_ready = 1'b0;

  logic       line_q [0:65535];
  logic [7:0] m_data;
  logic       m_valid, m_fe, m_ov;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(C4)) dut4 (
    .clk(clk), .rst(rst4), .uart_rx(rx4), .data(data4), .valid(valid4),
    .ready(ready4), .frame_err(fe4), .overrun(ov4)
  );

  uart_receiver dut234 (
    .clk(clk), .rst(rst234), .uart_rx(rx234), .data(data234), .valid(valid234),
    .ready(ready234), .frame_err(fe234), .overrun(ov234)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) ready4 = ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic send_bits(input logic [7:0] b);
    rx4 = 1'b0;
    tick(C4);
    for (int i = 0; i < 8; i++) begin
      rx4 = b[i];
      tick(C4);
    end
  endtask

  task automatic send4(input logic [7:0] b);
    send_bits(b);
    rx4 = 1'b1;
    tick(C4);
  endtask

  // Behavioural model: edge n acts on the line value flop 1 captured at edge n-2.
  initial begin
    int         e0m;
    int         idle_line;
    int         rel;
    bit         recovering;
    bit         deliver;
    logic       lv;
    logic [7:0] sh;
    e0m = -1; idle_line = 1 << 30; recovering = 1'b0; sh = '0;
    m_data = '0; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc < 65536) line_q[cyc] = rx4;
      m_fe = 1'b0;
      m_ov = 1'b0;
      deliver = 1'b0;
      if (rst4) begin
        armed = 1'b1;
        e0m = -1;
        recovering = 1'b0;
        idle_line = cyc + 1;
        m_data = '0;
        m_valid = 1'b0;
      end else begin
        lv = (cyc >= 2 && cyc - 2 < 65536) ? line_q[cyc-2] : 1'b1;
        if (recovering) begin
          if (lv) begin
            recovering = 1'b0;
            idle_line = cyc - 1;
          end
        end else if (e0m < 0) begin
          if (cyc - 2 >= idle_line && !lv) e0m = cyc - 2;
        end else begin
          rel = cyc - 2 - e0m;
          if (rel == H4) begin
            if (lv) begin
              e0m = -1;
              idle_line = cyc - 1;
            end
          end else if (rel > H4 && rel < H4 + 9 * C4 && (rel - H4) % C4 == 0) begin
            sh[(rel-H4)/C4-1] = lv;
          end else if (rel == H4 + 9 * C4) begin
            e0m = -1;
            if (lv) begin
              deliver = 1'b1;
              idle_line = cyc - 1;
            end else begin
              m_fe = 1'b1;
              recovering = 1'b1;
            end
          end
        end
        if (deliver) begin
          if (!m_valid || ready4) begin
            m_data = sh;
            m_valid = 1'b1;
          end else begin
            m_ov = 1'b1;
          end
        end else if (m_valid && ready4) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed)
        check("cycle_model", {20'd0, data4, valid4, fe4, ov4, 1'b0},
              {20'd0, m_data, m_valid, m_fe, m_ov, 1'b0});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int         e0;
    int         rise;
    int         sel;
    logic [7:0] b;
    bit         found;
    rx4 = 1'b1; rx234 = 1'b1; ready4 = 1'b0; ready234 = 1'b0;
    rst4 = 1'b1; rst234 = 1'b1;
    tick(3);
    rst4 = 1'b0; rst234 = 1'b0;
    check("reset_valid", 32'(valid4), 32'd0);
    check("reset_data", 32'(data4), 32'd0);
    check("reset_pulses", 32'({fe4, ov4}), 32'd0);
    check("reset_valid234", 32'(valid234), 32'd0);
    tick(5);

    // 0xA5 with ready low: valid must rise exactly at E0+40.
    e0 = cyc + 1;
    send4(8'hA5);
    check("a5_not_early", 32'(valid4), 32'd0);
    tick(1);
    check("a5_latency", 32'(cyc - e0), 32'd40);
    check("a5_valid", 32'(valid4), 32'd1);
    check("a5_data", 32'(data4), 32'hA5);
    check("a5_pulses", 32'({fe4, ov4}), 32'd0);
    ready4 = 1'b1;
    tick(1);
    ready4 = 1'b0;
    check("a5_drained", 32'(valid4), 32'd0);
    tick(4);

    rx4 = 1'b0;
    tick(2);
    rx4 = 1'b1;
    tick(12);
    check("glitch_valid", 32'(valid4), 32'd0);
    send4(8'h3C);
    tick(1);
    check("3c_valid", 32'(valid4), 32'd1);
    check("3c_data", 32'(data4), 32'h3C);
    ready4 = 1'b1; tick(1); ready4 = 1'b0;
    tick(3);

    // Stop bit held low: frame error pulse at E0+40, then recovery.
    e0 = cyc + 1;
    send_bits(8'h55);
    rx4 = 1'b0;
    tick(4);
    check("fe_not_early", 32'(fe4), 32'd0);
    tick(1);
    check("fe_latency", 32'(cyc - e0), 32'd40);
    check("fe_pulse", 32'(fe4), 32'd1);
    check("fe_no_valid", 32'(valid4), 32'd0);
    tick(1);
    check("fe_one_cycle", 32'(fe4), 32'd0);
    tick(14);
    rx4 = 1'b1;
    tick(8);
    send4(8'h0F);
    tick(1);
    check("0f_valid", 32'(valid4), 32'd1);
    check("0f_data", 32'(data4), 32'h0F);
    ready4 = 1'b1; tick(1); ready4 = 1'b0;
    tick(3);

    send4(8'h11);
    send4(8'h22);
    tick(1);
    check("ovr_pulse", 32'(ov4), 32'd1);
    check("ovr_data_kept", 32'(data4), 32'h11);
    tick(1);
    check("ovr_one_cycle", 32'(ov4), 32'd0);
    ready4 = 1'b1; tick(1); ready4 = 1'b0;
    tick(3);

    fork
      begin
        send4(8'h11);
        send4(8'h22);
      end
      begin
        tick(80);
        ready4 = 1'b1;
        tick(1);
        ready4 = 1'b0;
      end
    join
    check("swap_data", 32'(data4), 32'h22);
    check("swap_valid", 32'(valid4), 32'd1);
    check("swap_no_ovr", 32'(ov4), 32'd0);
    tick(3);

    // Reset in the middle of data bit 4 of 0xE3, while 0x22 is still held.
    b = 8'hE3;
    rx4 = 1'b0;
    tick(C4);
    for (int i = 0; i < 4; i++) begin
      rx4 = b[i];
      tick(C4);
    end
    rx4 = b[4];
    tick(1);
    rst4 = 1'b1;
    tick(1);
    rst4 = 1'b0;
    check("rst_valid", 32'(valid4), 32'd0);
    check("rst_data", 32'(data4), 32'd0);
    check("rst_pulses", 32'({fe4, ov4}), 32'd0);
    tick(2);
    for (int i = 5; i < 8; i++) begin
      rx4 = b[i];
      tick(C4);
    end
    rx4 = 1'b1;
    tick(C4 + 12);
    check("rst_no_byte", 32'(valid4), 32'd0);
    send4(8'hC3);
    tick(1);
    check("c3_data", 32'(data4), 32'hC3);
    check("c3_valid", 32'(valid4), 32'd1);
    ready4 = 1'b1; tick(1); ready4 = 1'b0;
    tick(3);

    rand_ready = 1'b1;
    for (int it = 0; it < 200; it++) begin
      sel = int'($urandom_range(0, 99));
      b = 8'($urandom);
      if (sel < 70) begin
        send4(b);
      end else if (sel < 82) begin
        send_bits(b);
        rx4 = 1'b0;
        tick(int'($urandom_range(1, 12)));
        rx4 = 1'b1;
      end else if (sel < 94) begin
        rx4 = 1'b0;
        tick(int'($urandom_range(1, 5)));
        rx4 = 1'b1;
      end else begin
        rst4 = 1'b1;
        tick(1);
        rst4 = 1'b0;
      end
      tick(int'($urandom_range(0, 6)));
    end
    rand_ready = 1'b0;
    ready4 = 1'b1;
    tick(2);
    ready4 = 1'b0;
    tick(60);

    // Default bit period: 0xFF means a start bit followed by a line held high.
    e0 = cyc + 1;
    rx234 = 1'b0;
    tick(234);
    rx234 = 1'b1;
    found = 1'b0;
    rise = -1;
    for (int k = 0; k < 3000 && !found; k++) begin
      tick(1);
      if (valid234 === 1'b1) begin
        found = 1'b1;
        rise = cyc;
      end
    end
    check("c234_latency", 32'(rise - e0), 32'd2225);
    check("c234_data", 32'(data234), 32'hFF);
    check("c234_pulses", 32'({fe234, ov234}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver for the GPU top: accepts 8N1 frames on `uart_rx` and presents each byte on a valid/ready holding register to the command logic. Complements the transmit path on the same link: the host sends bytes in, the GPU's transmitter sends bytes out. The block reports framing errors and overruns as single-cycle pulses, and never stalls the line.

## Interface
- `CLKS_PER_BIT`, default 234 (27 MHz / 115200 baud): clk cycles per bit; must be >= 4. H = CLKS_PER_BIT/2, truncated.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input; idles high.
- `data`  out  8  received byte; stable while `valid`=1.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` on a cycle where `valid`&&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a good byte completed while the holding register was full and not being drained.

## Operation
- Synchronizer: 2 flops on `uart_rx`; both reset to 1. All decisions use the second flop (`rx_s`).
- Bit counter: width $clog2(CLKS_PER_BIT). Bit index: 3 bits. Shift register: 8 bits, LSB first (shift right, new bit into bit 7).
- States:
  - IDLE
    - `rx_s`=0 -> START, counter=0.
  - START
    - Counter increments each cycle.
    - At counter==H-1, sample `rx_s`: 0 -> DATA with counter=0 and index=0; 1 -> IDLE (glitch rejected; no pulse).
  - DATA
    - At counter==C-1 (C=CLKS_PER_BIT), shift in `rx_s` and set counter=0.
    - After the 8th bit (index==7) -> STOP.
  - STOP
    - At counter==C-1, sample `rx_s`: 1 -> deliver byte, then IDLE; 0 -> pulse `frame_err`, drop byte, -> RECOVER.
  - RECOVER
    - Wait for `rx_s`=1, then IDLE. This blocks false restarts during a break.
- Delivery on a good stop bit, resolved in the same cycle:
  - `valid`=0: load `data`, set `valid`=1.
  - `valid`=1 and `ready`=1: load the new byte; `valid` stays 1; no overrun.
  - `valid`=1 and `ready`=0: keep the old byte, discard the new one, pulse `overrun`.
- Handshake:
  - `valid`&&`ready` with no delivery that cycle -> `valid`=0 next cycle.
  - `data` is unchanged unless loaded. `ready` while `valid`=0 has no effect.
- Reset, at any point including mid-frame:
  - State IDLE; counter, index and shift register 0.
  - `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0; synchronizer = 1.
  - A frame in progress is abandoned with no pulse.

## Timing
- Let edge E0 be the first clk edge at which `uart_rx` is sampled low by flop 1.
- IDLE sees `rx_s`=0 at E0+1; START is entered at E0+2.
- Start sample at E0+1+H. Data bit k (k=1..8) is sampled at E0+1+H+k·C. Stop sample at E0+1+H+9·C.
- `valid` rises, or `frame_err`/`overrun` pulses, registered one edge after the stop sample: at E0+2+H+9·C. For C=4 this is E0+40.
- The block is back in IDLE at that same edge, so a new start bit can be detected on the next cycle. Back-to-back frames with a 1-bit stop are supported.
- Pulses are exactly 1 cycle wide. `valid` drops 1 cycle after the accepting edge.
- Throughput: 1 byte per 10·C cycles. The consumer has about 10·C cycles to drain before an overrun.

## Test plan
- C=4, send 0xA5 (line low 4 cycles, bits 1,0,1,0,0,1,0,1 LSB first, stop high) with `ready`=0 -> `valid`=1 at E0+40, `data`=0xA5, no pulses; assert `ready` for 1 cycle -> `valid`=0 next cycle.
- 2-cycle low glitch on an idle line -> returns to IDLE, `valid` stays 0, no pulses; a following 0x3C frame is received correctly.
- Send 0x55 with the stop bit held low for 20 cycles -> `frame_err` 1-cycle pulse at E0+40, `valid` stays 0; line then returns high and 0x0F is sent -> `valid`=1, `data`=0x0F.
- Send 0x11 then 0x22 back-to-back with `ready`=0 -> `data`=0x11 retained, `overrun` pulse on the second delivery; repeat with `ready`=1 exactly on the second delivery cycle -> `data`=0x22, `valid` stays 1, no `overrun`.
- Assert `rst` during DATA bit 4 of a frame -> next cycle `valid`=0, `data`=0x00, no pulses; the remaining bits of that frame, which contain 0 bits, are not accepted as a byte; a subsequent clean 0xC3 is received.
- Default C=234: send 0xFF -> `valid` at E0+2+117+2106 = E0+2225, `data`=0xFF.
